uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
- REQ-001 Parameter NBITS, default 8, data bits per frame; legal range 5..9.
- REQ-002 Parameter OVERSAMPLE, default 16, baud ticks per bit period; legal range 2..256.
- REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; must be a power of 2 and at least 2.
- REQ-004 clk  input  1  single clock; all logic on posedge clk.
- REQ-005 rst  input  1  synchronous, active-high reset.
- REQ-006 i_baud_rate  input  1  one-clk-wide oversample tick strobe.
- REQ-007 i_valid  input  1  write request into the FIFO.
- REQ-008 i_data  input  NBITS  write data.
- REQ-009 o_ready  output  1  FIFO can accept a word (not full).
- REQ-010 i_parity_mode  input  2  parity select: 00 none, 01 even, 10 odd, 11 none.
- REQ-011 i_stop2  input  1  0 = one stop bit, 1 = two stop bits.
- REQ-012 o_tx  output  1  serial line, registered, idle high.
- REQ-013 o_busy  output  1  high while any state other than IDLE is active.
- REQ-014 o_tx_done  output  1  one-clk pulse at frame end.
- REQ-015 o_fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
- REQ-016 A write shall occur when i_valid && o_ready; i_valid while full shall be dropped without side effects.
- REQ-017 The state machine shall have states IDLE, START, DATA, PARITY and STOP.
- REQ-018 In IDLE, when the FIFO is non-empty, the block shall pop one word, latch i_parity_mode and i_stop2, clear the tick and bit counters, and enter START.
- REQ-019 A push into an empty FIFO at cycle N while IDLE shall drive o_tx low at cycle N+2.
- REQ-020 Each bit shall last exactly OVERSAMPLE i_baud_rate ticks; the state advances on the tick where tick_count == OVERSAMPLE-1; cycles without a tick hold all state.
- REQ-021 START shall drive 0; DATA shall drive NBITS bits, LSB first.
- REQ-022 PARITY shall drive XOR(data) for even, ~XOR(data) for odd; the state is skipped when the latched mode is none.
- REQ-023 STOP shall drive 1 for one bit period, or two when the latched i_stop2 = 1.
- REQ-024 At the end of the last stop bit the block shall pulse o_tx_done for 1 clk and return to IDLE.
- REQ-025 If the FIFO is non-empty at that point, the next START shall begin in the following cycle with no extra idle bit.
- REQ-026 Changes to i_parity_mode or i_stop2 mid-frame shall affect only later frames.
- REQ-027 A push and an internal pop in the same cycle shall both occur, leaving the count unchanged.
- REQ-028 FIFO pointers shall wrap modulo FIFO_DEPTH.
- REQ-029 o_ready shall equal (o_fifo_count != FIFO_DEPTH).

Reset
- REQ-030 While rst = 1 at a clock edge the block shall set state IDLE, o_tx = 1, o_busy = 0, o_tx_done = 0, o_fifo_count = 0 and o_ready = 1, and clear all counters and the shift register.
- REQ-031 A reset mid-frame shall abort the frame, drive o_tx high from the next edge, discard FIFO contents and suppress o_tx_done.

Configuration
- REQ-032 With macro UART_TX_PARITY_EN defined, parity shall behave per REQ-022.
- REQ-033 With UART_TX_PARITY_EN undefined, the PARITY state and parity logic shall be absent, and i_parity_mode shall stay as a port but be ignored (frames always without parity).

Structure
- REQ-034 A shared package uart_pkg shall hold the state encoding, the parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and a clog2 helper function.
- REQ-035 The FIFO shall be the sub-module uart_tx_fifo, parameterised by width and depth, with push, pop, full, empty and count signals.
- REQ-036 The FSM, counters and shift register shall reside in uart_tx_cfg.

Verification
- REQ-037 Defaults, mode 00, stop2 0, baud tick every clk, push 0xA5 -> o_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clks, o_tx_done 160 clks after start.
- REQ-038 Mode 01 with 0x07 -> parity bit 1; mode 10 with 0x07 -> parity bit 0; frame length 11 bits.
- REQ-039 stop2 = 1 with 0xFF -> stop high for 32 ticks, then o_tx_done; stop2 toggled mid-frame -> current frame unaffected.
- REQ-040 Push 5 words back-to-back with FIFO_DEPTH 4 and a busy line -> 4 accepted (5th dropped because o_ready is 0), 4 frames sent contiguously, o_fifo_count ends at 0.
- REQ-041 Assert rst during DATA bit 3 -> o_tx = 1 next clk, o_fifo_count = 0, no o_tx_done pulse.
- REQ-042 Baud tick every 3rd clk with NBITS = 7 -> each bit lasts 48 clks, 7 data bits sent.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter.
//   tx_state_t : FSM state encoding (PARITY exists only with UART_TX_PARITY_EN)
//   PAR_*      : parity mode select values (2'b11 also means no parity)
//   clog2      : ceiling log2 for port and counter widths
// Build option: define UART_TX_PARITY_EN to include the parity state.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- transmit word FIFO, power-of-2 depth, pointers wrap naturally.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   push, wr_data     write request (ignored while full)
//   pop, rd_data      read request (ignored while empty); rd_data shows head word
//   full, empty       occupancy flags
//   count             current occupancy, 0..DEPTH
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [clog2(DEPTH):0]    count
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- configurable UART transmitter with a small transmit FIFO.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_baud_rate       one-clk oversample tick; OVERSAMPLE ticks per bit
//   i_valid, i_data   FIFO write (taken when o_ready)
//   o_ready           FIFO not full
//   i_parity_mode     00/11 none, 01 even, 10 odd (latched per frame)
//   i_stop2           two stop bits when 1 (latched per frame)
//   o_tx              registered serial line, idle high
//   o_busy            FSM not in IDLE
//   o_tx_done         one-clk pulse as the last stop bit ends on the line
//   o_fifo_count      FIFO occupancy
// Build option: UART_TX_PARITY_EN enables the parity bit; without it
// i_parity_mode is ignored and frames never carry parity.
//
// state  | meaning
// IDLE   | line high, pops the next word when the FIFO is non-empty
// START  | start bit (0)
// DATA   | NBITS data bits, LSB first
// PARITY | parity bit (parity builds only, skipped for mode none)
// STOP   | one or two stop bits (1)
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int NBITS      = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_baud_rate,
   input  logic                          i_valid,
   input  logic [NBITS-1:0]              i_data,
   output logic                          o_ready,
   input  logic [1:0]                    i_parity_mode,
   input  logic                          i_stop2,
   output logic                          o_tx,
   output logic                          o_busy,
   output logic                          o_tx_done,
   output logic [clog2(FIFO_DEPTH):0]    o_fifo_count
);

   localparam int              TW        = clog2(OVERSAMPLE);
   localparam int              BW        = clog2(NBITS);
   localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0]   DATA_LAST = BW'(NBITS - 1);

   tx_state_t        state;
   tx_state_t        state_nxt;
   logic [TW-1:0]    tick_cnt;
   logic [BW-1:0]    bit_cnt;
   logic [NBITS-1:0] shift_reg;
   logic [NBITS-1:0] fifo_rd_data;
   logic             stop2_q;
   logic             bit_end;
   logic             fifo_pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic             tx_bit;
   logic             frame_end;
   logic             done_pend;

`ifdef UART_TX_PARITY_EN
   logic             par_en_q;
   logic             par_bit_q;
`else
   logic             unused_parity_mode;
   assign unused_parity_mode = ^i_parity_mode;
`endif

   uart_tx_fifo #(
      .WIDTH (NBITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (i_valid),
      .pop     (fifo_pop),
      .wr_data (i_data),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (o_fifo_count)
   );

   assign o_ready = ~fifo_full;
   assign o_busy  = (state != IDLE);

   // tick_cnt counts down the ticks left in the current bit
   assign bit_end = i_baud_rate && (tick_cnt == '0);

   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      tx_bit    = 1'b1;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            tx_bit = 1'b0;
            if (bit_end) state_nxt = DATA;
         end
         DATA: begin
            tx_bit = shift_reg[0];
            if (bit_end && bit_cnt == '0) begin
`ifdef UART_TX_PARITY_EN
               state_nxt = par_en_q ? PARITY : STOP;
`else
               state_nxt = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_bit = par_bit_q;
            if (bit_end) state_nxt = STOP;
         end
`endif
         STOP: begin
            if (bit_end && bit_cnt == '0) begin
               state_nxt = IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // o_tx trails the state by one clk; done_pend delays o_tx_done by the
   // same amount so the pulse lines up with the end of the stop bit on the line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         stop2_q   <= 1'b0;
         done_pend <= 1'b0;
         o_tx      <= 1'b1;
         o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         o_tx      <= tx_bit;
         done_pend <= frame_end;
         o_tx_done <= done_pend;
         if (fifo_pop) begin
            tick_cnt  <= TICK_LAST;
            bit_cnt   <= '0;
            shift_reg <= fifo_rd_data;
            stop2_q   <= i_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= (i_parity_mode == PAR_EVEN) || (i_parity_mode == PAR_ODD);
            par_bit_q <= (i_parity_mode == PAR_ODD) ? ~^fifo_rd_data : ^fifo_rd_data;
`endif
         end else if (bit_end && state != IDLE) begin
            tick_cnt <= TICK_LAST;
            if (state == DATA) shift_reg <= shift_reg >> 1;
            if (state_nxt != state) begin
               case (state_nxt)
                  DATA:    bit_cnt <= DATA_LAST;
                  STOP:    bit_cnt <= BW'(stop2_q);
                  default: bit_cnt <= '0;
               endcase
            end else begin
               bit_cnt <= bit_cnt - BW'(1);
            end
         end else if (i_baud_rate) begin
            tick_cnt <= tick_cnt - TW'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: a default instance (NBITS 8, tick every clk) and a
// NBITS 7 instance ticked every third clk. Expected frames come from a
// bit-list model built from the frame format (start, data LSB first,
// optional parity from the ones count, stop bits).
module tb_uart_tx_cfg;

   localparam int NB    = 8;
   localparam int NB7   = 7;
   localparam int OS    = 16;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud;
   logic       valid;
   logic [7:0] data;
   logic       ready;
   logic [1:0] pmode;
   logic       stop2;
   logic       tx;
   logic       busy;
   logic       done;
   logic [2:0] fcount;

   logic       baud7 = 1'b0;
   logic       valid7;
   logic [6:0] data7;
   logic       ready7;
   logic [1:0] pmode7;
   logic       stop27;
   logic       tx7;
   logic       busy7;
   logic       done7;
   logic [2:0] fcount7;

   int tests = 0;
   int fails = 0;
   int div_cnt = 0;

   logic       exp_q[$];
   logic [7:0] wq[$];

   always #5 clk = ~clk;

   always @(negedge clk) begin
      div_cnt = (div_cnt + 1) % 3;
      baud7 = (div_cnt == 0);
   end

   uart_tx_cfg #(.NBITS(NB), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .i_baud_rate(baud), .i_valid(valid), .i_data(data),
      .o_ready(ready), .i_parity_mode(pmode), .i_stop2(stop2), .o_tx(tx),
      .o_busy(busy), .o_tx_done(done), .o_fifo_count(fcount)
   );

   uart_tx_cfg #(.NBITS(NB7), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut7 (
      .clk(clk), .rst(rst), .i_baud_rate(baud7), .i_valid(valid7), .i_data(data7),
      .o_ready(ready7), .i_parity_mode(pmode7), .i_stop2(stop27), .o_tx(tx7),
      .o_busy(busy7), .o_tx_done(done7), .o_fifo_count(fcount7)
   );

   // Expected line bits of one frame, one entry per bit period.
   function automatic void build_frame(input logic [8:0] d, input int nb,
                                       input logic [1:0] mode, input logic s2);
      int   ones;
      logic par_on;
      ones   = 0;
      par_on = 1'b0;
      exp_q.delete();
      exp_q.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(d[i]);
         if (d[i]) ones++;
      end
`ifdef UART_TX_PARITY_EN
      par_on = (mode == 2'b01) || (mode == 2'b10);
`endif
      if (par_on) exp_q.push_back(((ones % 2) == 1) ^ (mode == 2'b10));
      exp_q.push_back(1'b1);
      if (s2) exp_q.push_back(1'b1);
   endfunction

   task automatic push_word(input logic [7:0] d);
      valid = 1'b1;
      data  = d;
      @(negedge clk);
      valid = 1'b0;
   endtask

   // Waits for the start bit of dut, then checks every sample of every bit
   // in exp_q and the o_tx_done pulse right after the last stop bit.
   task automatic check_frame(input string name, output int waited);
      int bad;
      waited = 0;
      while (tx !== 1'b0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      tests++;
      if (tx !== 1'b0) begin
         fails++;
         $display("FAIL %s start: o_tx=%b, required 0 within 400 clks", name, tx);
         return;
      end
      foreach (exp_q[b]) begin
         bad = 0;
         for (int s = 0; s < OS; s++) begin
            if (tx !== exp_q[b] || done !== 1'b0) bad++;
            @(negedge clk);
         end
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL %s bit %0d: %0d of %0d samples wrong, required o_tx=%b o_tx_done=0",
                     name, b, bad, OS, exp_q[b]);
         end
      end
      tests++;
      if (done !== 1'b1 || tx !== 1'b1) begin
         fails++;
         $display("FAIL %s end: o_tx_done=%b o_tx=%b, required 1 1", name, done, tx);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fcount !== 3'd0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL reset: tx=%b busy=%b done=%b count=%0d ready=%b, required 1 0 0 0 1",
                  tx, busy, done, fcount, ready);
      end
      tests++;
      if (tx7 !== 1'b1 || busy7 !== 1'b0 || done7 !== 1'b0 || fcount7 !== 3'd0 || ready7 !== 1'b1) begin
         fails++;
         $display("FAIL reset7: tx=%b busy=%b done=%b count=%0d ready=%b, required 1 0 0 0 1",
                  tx7, busy7, done7, fcount7, ready7);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int w;
      pmode = 2'b00;
      stop2 = 1'b0;
      build_frame(9'h0A5, NB, 2'b00, 1'b0);
      push_word(8'hA5);
      check_frame("basic", w);
      tests++;
      if (w != 2) begin
         fails++;
         $display("FAIL basic latency: o_tx fell %0d clks after push edge, required 2", w);
      end
      @(negedge clk);
      tests++;
      if (busy !== 1'b0 || fcount !== 3'd0) begin
         fails++;
         $display("FAIL basic idle: busy=%b count=%0d, required 0 0", busy, fcount);
      end
   endtask

   task automatic test_parity();
      logic [1:0] modes [3];
      int w;
      modes[0] = 2'b01;
      modes[1] = 2'b10;
      modes[2] = 2'b11;
      stop2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pmode = modes[i];
         build_frame(9'h007, NB, modes[i], 1'b0);
         push_word(8'h07);
         check_frame($sformatf("parity mode %0d", modes[i]), w);
         @(negedge clk);
      end
   endtask

   task automatic test_stop2();
      logic [7:0] d;
      int w;
      pmode = 2'b00;
      stop2 = 1'b1;
      build_frame(9'h0FF, NB, 2'b00, 1'b1);
      push_word(8'hFF);
      check_frame("stop2", w);
      @(negedge clk);

      d = 8'($urandom_range(0, 255));
      pmode = 2'b01;
      stop2 = 1'b1;
      build_frame(9'(d), NB, 2'b01, 1'b1);
      push_word(d);
      fork
         check_frame("cfg change mid-frame", w);
         begin
            repeat (40) @(negedge clk);
            stop2 = 1'b0;
            pmode = 2'b10;
         end
      join
      @(negedge clk);

      d = 8'($urandom_range(0, 255));
      build_frame(9'(d), NB, 2'b10, 1'b0);
      push_word(d);
      check_frame("cfg after change", w);
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic [1:0] m;
      logic       s;
      int         w;
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         m = 2'($urandom_range(0, 3));
         s = 1'($urandom_range(0, 1));
         pmode = m;
         stop2 = s;
         build_frame(9'(d), NB, m, s);
         push_word(d);
         check_frame($sformatf("random %0d d=%h m=%0d s=%0d", i, d, m, s), w);
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int bad;
      pmode = 2'b00;
      stop2 = 1'b0;
      wq.delete();
      wq.push_back(8'h3C);
      push_word(8'h3C);
      fork
         begin : rx_side
            logic [7:0] w;
            int         waited;
            for (int f = 0; f < 5; f++) begin
               if (wq.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL b2b frames: model queue empty at frame %0d, required 5 frames", f);
                  break;
               end
               w = wq.pop_front();
               build_frame(9'(w), NB, 2'b00, 1'b0);
               check_frame($sformatf("b2b frame %0d", f), waited);
               if (f > 0) begin
                  tests++;
                  if (waited != 1) begin
                     fails++;
                     $display("FAIL b2b gap %0d: start %0d clks after done, required 1", f, waited);
                  end
               end
            end
         end
         begin : tx_side
            logic [7:0] d;
            logic       exp_rdy;
            repeat (10) @(negedge clk);
            for (int i = 0; i < 5; i++) begin
               d = 8'($urandom_range(0, 255));
               exp_rdy = (wq.size() < DEPTH);
               tests++;
               if (ready !== exp_rdy) begin
                  fails++;
                  $display("FAIL b2b ready %0d: o_ready=%b, required %b", i, ready, exp_rdy);
               end
               valid = 1'b1;
               data  = d;
               @(negedge clk);
               valid = 1'b0;
               if (exp_rdy) wq.push_back(d);
               tests++;
               if (fcount !== 3'(wq.size())) begin
                  fails++;
                  $display("FAIL b2b count %0d: o_fifo_count=%0d, required %0d", i, fcount, wq.size());
               end
            end
         end
      join
      @(negedge clk);
      tests++;
      if (fcount !== 3'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL b2b drain: count=%0d busy=%b, required 0 0", fcount, busy);
      end
      bad = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL b2b dropped word: o_tx low for %0d clks after last frame, required 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      int waited;
      int bad;
      pmode = 2'b00;
      stop2 = 1'b0;
      push_word(8'($urandom_range(0, 255)));
      push_word(8'($urandom_range(0, 255)));
      waited = 0;
      while (tx !== 1'b0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      tests++;
      if (tx !== 1'b0) begin
         fails++;
         $display("FAIL reset-mid start: o_tx=%b, required 0", tx);
      end
      repeat (70) @(negedge clk);
      tests++;
      if (busy !== 1'b1 || fcount !== 3'd1) begin
         fails++;
         $display("FAIL reset-mid pre: busy=%b count=%0d, required 1 1", busy, fcount);
      end
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (tx !== 1'b1 || fcount !== 3'd0 || busy !== 1'b0 || ready !== 1'b1) begin
         fails++;
         $display("FAIL reset-mid: tx=%b count=%0d busy=%b ready=%b, required 1 0 0 1",
                  tx, fcount, busy, ready);
      end
      rst = 1'b0;
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (done !== 1'b0 || tx !== 1'b1) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL reset-mid after: %0d clks with done or low line, required 0", bad);
      end
   endtask

   task automatic test_slow_baud();
      logic [6:0] d;
      int         k;
      d = {5'($urandom_range(0, 31)), 2'b01};
      pmode7 = 2'b00;
      stop27 = 1'b0;
      valid7 = 1'b1;
      data7  = d;
      @(negedge clk);
      valid7 = 1'b0;
      k = 0;
      while (tx7 !== 1'b0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (tx7 !== 1'b0) begin
         fails++;
         $display("FAIL slow start: o_tx=%b, required 0", tx7);
         return;
      end
      k = 0;
      while (tx7 !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      k = 0;
      while (tx7 !== 1'b0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k != 48) begin
         fails++;
         $display("FAIL slow bit0 length: %0d clks, required 48", k);
      end
      repeat (24) @(negedge clk);
      for (int i = 1; i < NB7; i++) begin
         tests++;
         if (tx7 !== d[i]) begin
            fails++;
            $display("FAIL slow data bit %0d: o_tx=%b, required %b", i, tx7, d[i]);
         end
         repeat (48) @(negedge clk);
      end
      tests++;
      if (tx7 !== 1'b1) begin
         fails++;
         $display("FAIL slow stop: o_tx=%b, required 1", tx7);
      end
      k = 0;
      while (done7 !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (done7 !== 1'b1) begin
         fails++;
         $display("FAIL slow done: o_tx_done=%b within 40 clks of mid-stop, required 1", done7);
      end
   endtask

   initial begin
      rst    = 1'b1;
      baud   = 1'b1;
      valid  = 1'b0;
      data   = '0;
      pmode  = 2'b00;
      stop2  = 1'b0;
      valid7 = 1'b0;
      data7  = '0;
      pmode7 = 2'b00;
      stop27 = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_stop2();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_slow_baud();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded 100000 clks, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
